// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator controller.
// Consumed by elevator_ctrl and elevator_next_dir.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        OPEN = 2'b10
    } state_t;

    // One-hot mask selecting a single floor in a pending-call vector.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input floor_t f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        m[f] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/elevator_next_dir.sv
// Combinational call scan: calls above/below/at the car and the direction
// the car should take after a stop, preferring to keep its last direction.
module elevator_next_dir
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pend_nxt_i,
    input  floor_t                position_i,
    input  dir_t                  last_dir_i,
    output logic                  any_above_o,
    output logic                  any_below_o,
    output logic                  here_o,
    output dir_t                  next_dir_o
);

    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (f > int'(position_i)) any_above_o = any_above_o | pend_nxt_i[f];
            if (f < int'(position_i)) any_below_o = any_below_o | pend_nxt_i[f];
        end
        here_o = pend_nxt_i[position_i];
    end

    // A car last heading down keeps going down while work remains below.
    always_comb begin
        next_dir_o = DIR_IDLE;
        if (last_dir_i == DIR_DOWN) begin
            if (any_below_o)      next_dir_o = DIR_DOWN;
            else if (any_above_o) next_dir_o = DIR_UP;
        end else begin
            if (any_above_o)      next_dir_o = DIR_UP;
            else if (any_below_o) next_dir_o = DIR_DOWN;
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car 4-floor elevator controller: latches calls, moves one floor per
// clock, stops with the door open. Macro ELEVATOR_DOOR_REOPEN_EN enables door reopen.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] button_up,
    input  logic [2:0] button_down,
    input  logic [3:0] button_in,
    output logic [2:0] position,
    output logic       open,
    output logic [1:0] direction,
    output state_t     dbg_state_o
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t                state_q;
    floor_t                pos_q;
    logic                  open_q;
    dir_t                  dir_q;
    dir_t                  last_dir_q;
    logic [NUM_FLOORS-1:0] pend_q;
    logic [CNT_W-1:0]      door_cnt_q;

    logic [NUM_FLOORS-1:0] pend_d;
    floor_t                pos_step_d;
    logic                  any_above;
    logic                  any_below;
    logic                  here;
    logic                  reopen;
    dir_t                  next_dir;

    // Merge the current button levels into the latched calls, per floor.
    always_comb begin
        pend_d    = pend_q;
        pend_d[0] = pend_d[0] | button_up[0] | button_in[0];
        pend_d[1] = pend_d[1] | button_up[1] | button_down[0] | button_in[1];
        pend_d[2] = pend_d[2] | button_up[2] | button_down[1] | button_in[2];
        pend_d[3] = pend_d[3] | button_down[2] | button_in[3];
    end

    always_comb begin
        pos_step_d = (dir_q == DIR_DOWN) ? pos_q - 2'd1 : pos_q + 2'd1;
`ifdef ELEVATOR_DOOR_REOPEN_EN
        reopen = here;
`else
        reopen = 1'b0;
`endif
    end

    elevator_next_dir u_next_dir (
        .pend_nxt_i  (pend_d),
        .position_i  (pos_q),
        .last_dir_i  (last_dir_q),
        .any_above_o (any_above),
        .any_below_o (any_below),
        .here_o      (here),
        .next_dir_o  (next_dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            open_q     <= 1'b0;
            dir_q      <= DIR_IDLE;
            last_dir_q <= DIR_UP;
            pend_q     <= '0;
            door_cnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (here) begin
                        open_q     <= 1'b1;
                        dir_q      <= DIR_IDLE;
                        pend_q     <= pend_d & ~floor_mask(pos_q);
                        door_cnt_q <= CNT_LOAD;
                        state_q    <= OPEN;
                    end else if (any_above) begin
                        dir_q   <= DIR_UP;
                        state_q <= MOVE;
                    end else if (any_below) begin
                        dir_q   <= DIR_DOWN;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    pos_q      <= pos_step_d;
                    last_dir_q <= dir_q;
                    if (pend_d[pos_step_d]) begin
                        open_q     <= 1'b1;
                        dir_q      <= DIR_IDLE;
                        pend_q     <= pend_d & ~floor_mask(pos_step_d);
                        door_cnt_q <= CNT_LOAD;
                        state_q    <= OPEN;
                    end
                end
                OPEN: begin
                    // Calls at the open floor are served by this stop.
                    pend_q <= pend_d & ~floor_mask(pos_q);
                    if (reopen) begin
                        door_cnt_q <= CNT_LOAD;
                    end else if (door_cnt_q == '0) begin
                        open_q  <= 1'b0;
                        dir_q   <= next_dir;
                        state_q <= (next_dir == DIR_IDLE) ? IDLE : MOVE;
                    end else begin
                        door_cnt_q <= door_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign position    = {1'b0, pos_q};
    assign open        = open_q;
    assign direction   = dir_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed testbench for elevator_ctrl with a two-cycle door; expectations
// are hand-derived. The reopen case follows ELEVATOR_DOOR_REOPEN_EN.
module tb_elevator_ctrl;
    import elevator_pkg::*;

    localparam int DC = 2;

    logic       clk;
    logic       reset;
    logic [2:0] button_up;
    logic [2:0] button_down;
    logic [3:0] button_in;
    logic [2:0] position;
    logic       open;
    logic [1:0] direction;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    elevator_ctrl #(.DOOR_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .button_up   (button_up),
        .button_down (button_down),
        .button_in   (button_in),
        .position    (position),
        .open        (open),
        .direction   (direction),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int pos, input logic op, input dir_t dir);
        check_eq({tag, ".pos"}, {5'd0, position}, 8'(pos));
        check_eq({tag, ".open"}, {7'd0, open}, {7'd0, op});
        check_eq({tag, ".dir"}, {6'd0, direction}, {6'd0, dir});
    endtask

    task automatic expect_state(input string tag, input state_t st);
        check_eq({tag, ".state"}, {6'd0, dbg_state}, {6'd0, st});
    endtask

    // Advance one edge and settle before sampling or re-driving inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        button_up   = '0;
        button_down = '0;
        button_in   = '0;
        tick();
        tick();
        reset = 1'b0;
        expect_out("rst", 0, 1'b0, DIR_IDLE);
        expect_state("rst", IDLE);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("idle%0d", i), 0, 1'b0, DIR_IDLE);
        end

        // Hall up call at the current floor opens the door.
        button_up = 3'b001;
        tick();
        button_up = '0;
        expect_out("t2_open", 0, 1'b1, DIR_IDLE);
        expect_state("t2_open", OPEN);

        // Cabin call to floor 2 while the door is open.
        button_in = 4'b0100;
        tick();
        button_in = '0;
        expect_out("t2_hold", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t3_close", 0, 1'b0, DIR_UP);
        expect_state("t3_close", MOVE);
        tick();
        expect_out("t3_f1", 1, 1'b0, DIR_UP);
        tick();
        expect_out("t3_f2", 2, 1'b1, DIR_IDLE);

        // Floor-3 down call and floor-0 cabin call together at floor 2.
        button_down = 3'b100;
        button_in   = 4'b0001;
        tick();
        button_down = '0;
        button_in   = '0;
        expect_out("t4_hold", 2, 1'b1, DIR_IDLE);
        tick();
        expect_out("t4_close", 2, 1'b0, DIR_UP);
        tick();
        expect_out("t4_f3", 3, 1'b1, DIR_IDLE);
        tick();
        expect_out("t4_f3_hold", 3, 1'b1, DIR_IDLE);
        tick();
        expect_out("t4_rev", 3, 1'b0, DIR_DOWN);
        tick();
        expect_out("t4_d2", 2, 1'b0, DIR_DOWN);
        tick();
        expect_out("t4_d1", 1, 1'b0, DIR_DOWN);
        tick();
        expect_out("t4_f0", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t4_f0_hold", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t4_idle", 0, 1'b0, DIR_IDLE);
        expect_state("t4_idle", IDLE);

        // Reset while moving at floor 2 drops the pending floor-3 call.
        button_in = 4'b1000;
        tick();
        button_in = '0;
        expect_out("t5_go", 0, 1'b0, DIR_UP);
        tick();
        expect_out("t5_f1", 1, 1'b0, DIR_UP);
        tick();
        expect_out("t5_f2", 2, 1'b0, DIR_UP);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("t5_rst", 0, 1'b0, DIR_IDLE);
        expect_state("t5_rst", IDLE);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("t5_lost%0d", i), 0, 1'b0, DIR_IDLE);
        end

        // Pressing the current floor while the door is open.
        button_in = 4'b0001;
        tick();
        expect_out("t6_open", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t6_e1", 0, 1'b1, DIR_IDLE);
`ifdef ELEVATOR_DOOR_REOPEN_EN
        tick();
        expect_out("t6_e2", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t6_e3", 0, 1'b1, DIR_IDLE);
        button_in = '0;
        tick();
        expect_out("t6_rel1", 0, 1'b1, DIR_IDLE);
        tick();
        expect_out("t6_rel2", 0, 1'b0, DIR_IDLE);
`else
        button_in = '0;
        tick();
        expect_out("t6_close", 0, 1'b0, DIR_IDLE);
        tick();
        expect_out("t6_idle", 0, 1'b0, DIR_IDLE);
`endif
        expect_state("t6_end", IDLE);

        // Travel to floor 3, then calls below: stop at 2 on the way to 0.
        button_in = 4'b1000;
        tick();
        button_in = '0;
        expect_out("t7_go", 0, 1'b0, DIR_UP);
        tick();
        expect_out("t7_f1", 1, 1'b0, DIR_UP);
        tick();
        expect_out("t7_f2", 2, 1'b0, DIR_UP);
        tick();
        expect_out("t7_f3", 3, 1'b1, DIR_IDLE);
        tick();
        tick();
        expect_out("t7_idle3", 3, 1'b0, DIR_IDLE);
        button_up = 3'b001;
        button_in = 4'b0100;
        tick();
        button_up = '0;
        button_in = '0;
        expect_out("t7_down", 3, 1'b0, DIR_DOWN);
        tick();
        expect_out("t7_stop2", 2, 1'b1, DIR_IDLE);
        tick();
        tick();
        expect_out("t7_keep", 2, 1'b0, DIR_DOWN);
        tick();
        expect_out("t7_d1", 1, 1'b0, DIR_DOWN);
        tick();
        expect_out("t7_f0", 0, 1'b1, DIR_IDLE);
        tick();
        tick();
        expect_out("t7_idle", 0, 1'b0, DIR_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
